// File: rtl/pkg_mem_arb.sv
// Shared types and constants for the instruction-fetch / LSU memory arbiter.
package pkg_mem_arb;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mem_arb_starve.sv
// Counts consecutive LSU wins while fetch waits; forces a fetch grant once the limit is hit.
module mem_arb_starve #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_if_req,
  input  logic i_ls_req,
  output logic o_fetch_force
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;

  assign o_fetch_force = (starve_cnt == CW'(STARVE_MAX));

  // Grows only while both contend and LSU wins; any fetch grant or idle fetch clears it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      starve_cnt <= '0;
    end else if (i_if_req && i_ls_req && !o_fetch_force) begin
      starve_cnt <= starve_cnt + CW'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the LSU, LSU priority
// with bounded fetch starvation, and 1-cycle read data routing back to the issuer.
module mem_arbiter
  import pkg_mem_arb::*;
#(
  parameter int unsigned MEM_AW     = 13,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [31:0]       i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [31:0]       o_if_rdata,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [3:0]        i_ls_be,
  input  logic [31:0]       i_ls_addr,
  input  logic [31:0]       i_ls_wdata,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [31:0]       o_ls_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_be,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  logic   fetch_force;
  logic   ls_store;
  owner_t owner_q;
  owner_t owner_d;

  mem_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_if_req     (i_if_req),
    .i_ls_req     (i_ls_req),
    .o_fetch_force(fetch_force)
  );

  // Grants are combinational and suppressed while reset is held.
  assign o_ls_gnt = i_rst_n & i_ls_req & ~(i_if_req & fetch_force);
  assign o_if_gnt = i_rst_n & i_if_req & (~i_ls_req | fetch_force);

  assign ls_store    = o_ls_gnt & i_ls_we;
  assign o_mem_en    = o_if_gnt | o_ls_gnt;
  assign o_mem_we    = ls_store;
  assign o_mem_be    = ls_store ? i_ls_be : BE_ALL;
  assign o_mem_addr  = o_ls_gnt ? i_ls_addr[MEM_AW+1:2] : i_if_addr[MEM_AW+1:2];
  assign o_mem_wdata = i_ls_wdata;

  // Byte offset and bits above the memory range are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, i_if_addr[31:MEM_AW+2], i_if_addr[1:0],
                              i_ls_addr[31:MEM_AW+2], i_ls_addr[1:0]};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Owner of the read issued this cycle; writes and idle cycles leave nobody waiting.
  always_comb begin
    owner_d = OWN_NONE;
    if (o_ls_gnt && !i_ls_we) begin
      owner_d = OWN_LS;
    end else if (o_if_gnt) begin
      owner_d = OWN_IF;
    end
  end

  assign o_if_rvalid = (owner_q == OWN_IF);
  assign o_ls_rvalid = (owner_q == OWN_LS);
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : 32'h0;
  assign o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_arbiter;

  localparam int unsigned MEM_AW = 13;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              ls_req;
  logic              ls_we;
  logic [3:0]        ls_be;
  logic [31:0]       ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [31:0]       ls_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [31:0] ram [0:(2**MEM_AW)-1];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_AW(MEM_AW), .STARVE_MAX(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .o_if_gnt   (if_gnt),
    .o_if_rvalid(if_rvalid),
    .o_if_rdata (if_rdata),
    .i_ls_req   (ls_req),
    .i_ls_we    (ls_we),
    .i_ls_be    (ls_be),
    .i_ls_addr  (ls_addr),
    .i_ls_wdata (ls_wdata),
    .o_ls_gnt   (ls_gnt),
    .o_ls_rvalid(ls_rvalid),
    .o_ls_rdata (ls_rdata),
    .o_mem_en   (mem_en),
    .o_mem_we   (mem_we),
    .o_mem_be   (mem_be),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  // RAM macro stand-in: byte-enabled write, registered read.
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end else if (mem_en) begin
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2**MEM_AW; i++) ram[i] = 32'h0;
    ram[0]     = 32'h0BAD_F00D;
    ram[4]     = 32'hDEAD_BEEF;
    ram[8]     = 32'hAAAA_AAAA;
    ram[16]    = 32'h1111_4040;
    ram[17]    = 32'h2222_4444;
    mem_rdata  = 32'h0;

    rst_n    = 1'b0;
    if_req   = 1'b1;
    if_addr  = 32'h0;
    ls_req   = 1'b1;
    ls_we    = 1'b0;
    ls_be    = 4'h0;
    ls_addr  = 32'h0;
    ls_wdata = 32'h0;

    // Reset held with both requests pending
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("rst_if_gnt", 32'(if_gnt), 32'd0);
      chk("rst_ls_gnt", 32'(ls_gnt), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
    end
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);

    // Release: LSU wins first, load of word 0
    rst_n = 1'b1;
    #1;
    chk("rel_ls_gnt", 32'(ls_gnt), 32'd1);
    chk("rel_if_gnt", 32'(if_gnt), 32'd0);
    tick();
    if_req = 1'b0;
    ls_req = 1'b0;
    #1;
    chk("rel_ls_rvalid", 32'(ls_rvalid), 32'd1);
    chk("rel_ls_rdata", ls_rdata, 32'h0BAD_F00D);
    chk("rel_if_rvalid", 32'(if_rvalid), 32'd0);

    // Fetch-only read of 0x10
    tick();
    if_req  = 1'b1;
    if_addr = 32'h0000_0010;
    #1;
    chk("if_gnt", 32'(if_gnt), 32'd1);
    chk("if_ls_gnt", 32'(ls_gnt), 32'd0);
    chk("if_mem_addr", 32'(mem_addr), 32'd4);
    chk("if_mem_en", 32'(mem_en), 32'd1);
    chk("if_mem_we", 32'(mem_we), 32'd0);
    chk("if_mem_be", 32'(mem_be), 32'hF);
    tick();
    if_req = 1'b0;
    #1;
    chk("if_rvalid", 32'(if_rvalid), 32'd1);
    chk("if_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("if_ls_rvalid", 32'(ls_rvalid), 32'd0);

    // LSU store of low half to 0x20
    tick();
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_be    = 4'b0011;
    ls_addr  = 32'h0000_0020;
    ls_wdata = 32'h1234_5678;
    #1;
    chk("st_ls_gnt", 32'(ls_gnt), 32'd1);
    chk("st_mem_we", 32'(mem_we), 32'd1);
    chk("st_mem_be", 32'(mem_be), 32'h3);
    chk("st_mem_addr", 32'(mem_addr), 32'd8);
    chk("st_mem_wdata", mem_wdata, 32'h1234_5678);
    tick();
    ls_we = 1'b0;
    #1;
    chk("st_no_ls_rvalid", 32'(ls_rvalid), 32'd0);
    chk("st_no_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("ld_ls_gnt", 32'(ls_gnt), 32'd1);
    chk("ld_mem_we", 32'(mem_we), 32'd0);
    chk("ld_mem_be", 32'(mem_be), 32'hF);
    tick();
    ls_req = 1'b0;
    #1;
    chk("ld_ls_rvalid", 32'(ls_rvalid), 32'd1);
    chk("ld_ls_rdata", ls_rdata, 32'hAAAA_5678);

    // Continuous contention: LS x4 then IF, repeating
    tick();
    if_req  = 1'b1;
    if_addr = 32'h0000_0010;
    ls_req  = 1'b1;
    ls_addr = 32'h0000_0020;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stv_if_gnt", 32'(if_gnt), (i % 5 == 4) ? 32'd1 : 32'd0);
      chk("stv_ls_gnt", 32'(ls_gnt), (i % 5 == 4) ? 32'd0 : 32'd1);
      chk("stv_mem_addr", 32'(mem_addr), (i % 5 == 4) ? 32'd4 : 32'd8);
      tick();
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    tick();

    // Interleaved LSU read of 0x40 then fetch read of 0x44
    ls_req  = 1'b1;
    ls_addr = 32'h0000_0040;
    #1;
    chk("ilv_ls_gnt", 32'(ls_gnt), 32'd1);
    tick();
    ls_req  = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0000_0044;
    #1;
    chk("ilv_if_gnt", 32'(if_gnt), 32'd1);
    chk("ilv_ls_rvalid", 32'(ls_rvalid), 32'd1);
    chk("ilv_ls_rdata", ls_rdata, 32'h1111_4040);
    chk("ilv_if_rvalid0", 32'(if_rvalid), 32'd0);
    tick();
    if_req = 1'b0;
    #1;
    chk("ilv_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("ilv_if_rdata", if_rdata, 32'h2222_4444);
    chk("ilv_ls_rvalid1", 32'(ls_rvalid), 32'd0);
    tick();
    chk("ilv_idle_if", 32'(if_rvalid), 32'd0);
    chk("ilv_idle_ls", 32'(ls_rvalid), 32'd0);

    // Reset lands on the edge that would return an LSU load
    ls_req  = 1'b1;
    ls_addr = 32'h0000_0040;
    #1;
    chk("mr_ls_gnt", 32'(ls_gnt), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_gnt_forced", 32'(ls_gnt), 32'd0);
    tick();
    ls_req = 1'b0;
    #1;
    chk("mr_ls_rvalid", 32'(ls_rvalid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mr_post_ls_rvalid", 32'(ls_rvalid), 32'd0);
    chk("mr_post_if_rvalid", 32'(if_rvalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory (1-cycle read latency) between the instruction-fetch path and the load/store unit of the RISC-V core.
- Grants at most one access per cycle and routes read data back to the requester that issued the read.
- LSU has priority over fetch. A starvation counter guarantees that a waiting fetch is eventually served.
- Sits between the pc/imem fetch logic, the lsu, and the shared RAM macro.

Parameters:
- MEM_AW, 13, word-address width of the shared memory (depth 2**MEM_AW words).
- STARVE_MAX, 4, maximum consecutive LSU grants allowed while a fetch is waiting.

Ports:
- i_clk  in  1  global clock, rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_if_req  in  1  fetch request; held high until granted
- i_if_addr  in  32  fetch byte address
- o_if_gnt  out  1  fetch request accepted this cycle
- o_if_rvalid  out  1  o_if_rdata valid
- o_if_rdata  out  32  fetch read data
- i_ls_req  in  1  LSU request; held high until granted
- i_ls_we  in  1  1 = store, 0 = load
- i_ls_be  in  4  store byte enables
- i_ls_addr  in  32  LSU byte address
- i_ls_wdata  in  32  store data
- o_ls_gnt  out  1  LSU request accepted this cycle
- o_ls_rvalid  out  1  o_ls_rdata valid
- o_ls_rdata  out  32  load read data
- o_mem_en  out  1  memory access strobe
- o_mem_we  out  1  memory write enable
- o_mem_be  out  4  memory byte enables
- o_mem_addr  out  MEM_AW  memory word address
- o_mem_wdata  out  32  memory write data
- i_mem_rdata  in  32  memory read data, valid the cycle after a read strobe

Behaviour:
- Clocking and reset:
  - Single clock i_clk.
  - Reset is synchronous, active-low on i_rst_n.
  - On reset: starve counter = 0, read owner = NONE.
  - Reset values of outputs: o_if_rvalid = 0, o_ls_rvalid = 0, o_if_rdata = 0, o_ls_rdata = 0.
  - While i_rst_n = 0: o_if_gnt, o_ls_gnt, o_mem_en and o_mem_we are forced to 0.
- Grant logic (combinational, same cycle as the request):
  - Only the LSU requests: LSU granted.
  - Only fetch requests: fetch granted.
  - Both request and starve_cnt < STARVE_MAX: LSU granted; starve_cnt increments.
  - Both request and starve_cnt == STARVE_MAX: fetch granted; starve_cnt clears.
  - starve_cnt clears on any cycle in which fetch is granted or i_if_req = 0.
  - starve_cnt never exceeds STARVE_MAX.
- Memory drive:
  - o_mem_en = o_if_gnt | o_ls_gnt.
  - o_mem_addr = granted address [MEM_AW+1:2]; byte offset and upper bits are ignored.
  - o_mem_we = o_ls_gnt & i_ls_we. Fetch never writes.
  - o_mem_be = i_ls_be for an LSU store, otherwise 4'hF.
  - o_mem_wdata = i_ls_wdata.
  - When no request is granted, address and data are don't-care but must be stable.
- Read return:
  - A registered owner field (NONE / IF / LS) is set from the grant of any read; it is NONE after a write or an idle cycle.
  - In the next cycle:
    - owner IF: o_if_rvalid = 1 and o_if_rdata = i_mem_rdata.
    - owner LS: o_ls_rvalid = 1 and o_ls_rdata = i_mem_rdata.
  - rdata outputs are pass-through; their value is meaningless while the matching rvalid = 0.
  - Fixed read latency is 1 cycle.
  - Back-to-back reads to alternating owners are supported every cycle; the owner pipeline is 1 deep.
- Stores: no rvalid is generated; the write completes at the granting edge.
- Reset mid-operation: an outstanding read is dropped. No rvalid is produced in the cycle after reset.
- Requesters must not change address or data while req = 1 and gnt = 0. The arbiter does not latch requests.

Decomposition:
- Shared package (pkg_mem_arb):
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_IF, OWN_LS}.
  - Constant BE_ALL = 4'hF.
- One sub-module: mem_arb_starve, holding the starve counter and the fetch-override decision.
- Grant mux and owner register live in the top of the block.

Test Plan:
- Reset: hold i_rst_n = 0 with both reqs high for 3 cycles -> both gnts = 0, o_mem_en = 0, both rvalids = 0; first cycle after release -> o_ls_gnt = 1.
- Fetch-only read: i_if_addr = 0x0000_0010 -> o_if_gnt = 1, o_mem_addr = 4 the same cycle; next cycle o_if_rvalid = 1 with o_if_rdata = preloaded word 0xDEAD_BEEF.
- LSU store then load:
  - Store: addr 0x20, be = 4'b0011, wdata 0x1234_5678 -> o_mem_we = 1, o_mem_be = 4'b0011, no rvalid.
  - Load from 0x20 -> o_ls_rvalid one cycle later, data low half = 0x5678.
- Starvation, STARVE_MAX = 4: hold both reqs high continuously -> grant pattern LS, LS, LS, LS, IF, repeating; fetch waits at most 4 cycles.
- Interleaved reads: LSU read at addr 0x40, then fetch read at addr 0x44 on the next cycle -> o_ls_rvalid and o_if_rvalid in consecutive cycles, each carrying its own word, never both in the same cycle.
- Reset mid-read: grant an LSU load, then assert i_rst_n = 0 on the next edge -> o_ls_rvalid stays 0.
